// File: rtl/player_motion_pkg.sv
`default_nettype none
// ============================================================================
// Module : player_motion_pkg
// Desc   : Shared FSM state type, shadow-control struct and fixed-point
//          defaults for the per-frame player motion engine.
// Rev    : 1.0  initial release
// ============================================================================
package player_motion_pkg;

  localparam int DEF_QI       = 12;
  localparam int DEF_QF       = 12;
  localparam int DEF_MAP_BITS = 4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ROT0   = 4'd1,
    ST_ROT1   = 4'd2,
    ST_ROT2   = 4'd3,
    ST_ROT3   = 4'd4,
    ST_MOVX   = 4'd5,
    ST_MOVY   = 4'd6,
    ST_CHKX   = 4'd7,
    ST_CHKY   = 4'd8,
    ST_COMMIT = 4'd9
  } state_t;

  // Controls captured at the frame tick and held for the whole update
  typedef struct packed {
    logic       move_l;
    logic       move_r;
    logic       move_f;
    logic       move_b;
    logic       turn_l;
    logic       turn_r;
    logic [1:0] speed;
    logic       collide;
  } ctrl_t;

  // Constant fixed-point product with floor, used to pre-scale diagonal steps
  function automatic int fx_scale(input int a, input int b, input int qf);
    return (a * b) >>> qf;
  endfunction

endpackage
`default_nettype wire

// File: rtl/player_motion_fixed_mac.sv
`default_nettype none
// ============================================================================
// Module : fixed_mac
// Desc   : Combinational signed multiply-accumulate p = (a*b + c*d) >>> QF,
//          computed at double width and truncated back to W bits.
// Rev    : 1.0  initial release
// ============================================================================
module fixed_mac
  import player_motion_pkg::*;
#(
  parameter int W  = DEF_QI + DEF_QF,
  parameter int QF = DEF_QF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  input  logic signed [W-1:0] d,
  output logic signed [W-1:0] p
);

  localparam int W2 = 2 * W;

  logic signed [W2-1:0] w_sum;

  // Full-precision sum of both products
  always_comb begin
    w_sum = W2'(a) * W2'(b) + W2'(c) * W2'(d);
  end

  assign p = W'(w_sum >>> QF);

endmodule
`default_nettype wire

// File: rtl/player_motion.sv
`default_nettype none
// ============================================================================
// Module : player_motion
// Desc   : Per-frame player state engine: facing-relative walk/strafe,
//          turning, speed select, diagonal scaling and axis-separated map
//          collision; publishes position/facing/vplane atomically.
// Rev    : 1.0  initial release
// ============================================================================
module player_motion
  import player_motion_pkg::*;
#(
  parameter int QI         = DEF_QI,
  parameter int QF         = DEF_QF,
  parameter int MAP_BITS   = DEF_MAP_BITS,
  parameter int X_START    = 8192,
  parameter int Y_START    = 55296,
  parameter int FX_START   = 0,
  parameter int FY_START   = -4096,
  parameter int VX_START   = 2048,
  parameter int VY_START   = 0,
  parameter int STEP_CRAWL = 32,
  parameter int STEP_WALK  = 80,
  parameter int STEP_RUN   = 144,
  parameter int ROT_COS    = 4076,
  parameter int ROT_SIN    = 401,
  parameter int INV_SQRT2  = 2896
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       moveL,
  input  logic                       moveR,
  input  logic                       moveF,
  input  logic                       moveB,
  input  logic                       turnL,
  input  logic                       turnR,
  input  logic [1:0]                 speed,
  input  logic                       collide_en,
  output logic                       map_req,
  output logic [MAP_BITS-1:0]        map_col,
  output logic [MAP_BITS-1:0]        map_row,
  input  logic                       map_ack,
  input  logic [1:0]                 map_val,
  output logic signed [QI+QF-1:0]    playerX,
  output logic signed [QI+QF-1:0]    playerY,
  output logic signed [QI+QF-1:0]    facingX,
  output logic signed [QI+QF-1:0]    facingY,
  output logic signed [QI+QF-1:0]    vplaneX,
  output logic signed [QI+QF-1:0]    vplaneY,
  output logic                       busy,
  output logic                       done,
  output logic                       missed_tick
);

  localparam int W          = QI + QF;
  localparam int DIAG_CRAWL = fx_scale(STEP_CRAWL, INV_SQRT2, QF);
  localparam int DIAG_WALK  = fx_scale(STEP_WALK,  INV_SQRT2, QF);
  localparam int DIAG_RUN   = fx_scale(STEP_RUN,   INV_SQRT2, QF);
  localparam logic signed [W-1:0] ONE = W'(1 << QF);

  state_t state, state_nxt;
  ctrl_t  r_ctrl;

  logic signed [W-1:0] r_px, r_py, r_fx, r_fy, r_vx, r_vy;
  logic signed [W-1:0] r_nfx, r_nfy, r_nvx, r_nvy;
  logic signed [W-1:0] r_cx, r_cy, r_rx, r_ry;
  logic                r_done, r_missed;

  logic signed [W-1:0] w_cos, w_sin, w_step, w_df, w_ds;
  logic signed [W-1:0] w_ma, w_mb, w_mc, w_md, w_mp;
  logic                w_diag, w_cx_in, w_cy_in, w_wall, w_chk_go;

  // Turn coefficients, step size and signed forward/strafe amounts from shadow controls
  always_comb begin
    w_cos  = ONE;
    w_sin  = '0;
    if (r_ctrl.turn_l) begin
      w_cos = W'(ROT_COS);
      w_sin = -W'(ROT_SIN);
    end else if (r_ctrl.turn_r) begin
      w_cos = W'(ROT_COS);
      w_sin = W'(ROT_SIN);
    end
    w_diag = (r_ctrl.move_f | r_ctrl.move_b) & (r_ctrl.move_l | r_ctrl.move_r);
    case (r_ctrl.speed)
      2'd0:    w_step = W'(w_diag ? DIAG_CRAWL : STEP_CRAWL);
      2'd1:    w_step = W'(w_diag ? DIAG_WALK  : STEP_WALK);
      default: w_step = W'(w_diag ? DIAG_RUN   : STEP_RUN);
    endcase
    w_df = '0;
    if (r_ctrl.move_f)      w_df = w_step;
    else if (r_ctrl.move_b) w_df = -w_step;
    w_ds = '0;
    if (r_ctrl.move_l)      w_ds = -w_step;
    else if (r_ctrl.move_r) w_ds = w_step;
  end

  // Operand steering for the single shared MAC, one product pair per state
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    w_mc = '0;
    w_md = '0;
    case (state)
      ST_ROT0: begin w_ma = r_fx; w_mb = w_cos; w_mc = r_fy;  w_md = -w_sin; end
      ST_ROT1: begin w_ma = r_fx; w_mb = w_sin; w_mc = r_fy;  w_md = w_cos;  end
      ST_ROT2: begin w_ma = r_vx; w_mb = w_cos; w_mc = r_vy;  w_md = -w_sin; end
      ST_ROT3: begin w_ma = r_vx; w_mb = w_sin; w_mc = r_vy;  w_md = w_cos;  end
      ST_MOVX: begin w_ma = w_df; w_mb = r_nfx; w_mc = w_ds;  w_md = -r_nfy; end
      ST_MOVY: begin w_ma = w_df; w_mb = r_nfy; w_mc = w_ds;  w_md = r_nfx;  end
      default: ;
    endcase
  end

  fixed_mac #(.W(W), .QF(QF)) u_mac (
    .a (w_ma),
    .b (w_mb),
    .c (w_mc),
    .d (w_md),
    .p (w_mp)
  );

  // Candidate is inside the map only when its integer part lies in [0, 2^MAP_BITS)
  assign w_cx_in = (r_cx[W-1:QF+MAP_BITS] == '0);
  assign w_cy_in = (r_cy[W-1:QF+MAP_BITS] == '0);

  // Map query port; out-of-map candidates are walls and never raise a request
  always_comb begin
    map_req  = 1'b0;
    map_col  = '0;
    map_row  = '0;
    w_chk_go = 1'b0;
    w_wall   = 1'b0;
    case (state)
      ST_CHKX: begin
        map_col  = r_cx[QF+MAP_BITS-1:QF];
        map_row  = r_py[QF+MAP_BITS-1:QF];
        map_req  = w_cx_in;
        w_chk_go = !w_cx_in || map_ack;
        w_wall   = !w_cx_in || (map_val != 2'b00);
      end
      ST_CHKY: begin
        map_col  = r_rx[QF+MAP_BITS-1:QF];
        map_row  = r_cy[QF+MAP_BITS-1:QF];
        map_req  = w_cy_in;
        w_chk_go = !w_cy_in || map_ack;
        w_wall   = !w_cy_in || (map_val != 2'b00);
      end
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Fixed update sequence; only the map checks may stall
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (tick) state_nxt = ST_ROT0;
      ST_ROT0:   state_nxt = ST_ROT1;
      ST_ROT1:   state_nxt = ST_ROT2;
      ST_ROT2:   state_nxt = ST_ROT3;
      ST_ROT3:   state_nxt = ST_MOVX;
      ST_MOVX:   state_nxt = ST_MOVY;
      ST_MOVY:   state_nxt = ST_CHKX;
      ST_CHKX:   if (w_chk_go) state_nxt = ST_CHKY;
      ST_CHKY:   if (w_chk_go) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Shadow controls, working vectors and the atomic commit of published state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl <= '0;
      r_px   <= W'(X_START);
      r_py   <= W'(Y_START);
      r_fx   <= W'(FX_START);
      r_fy   <= W'(FY_START);
      r_vx   <= W'(VX_START);
      r_vy   <= W'(VY_START);
      r_nfx  <= '0;
      r_nfy  <= '0;
      r_nvx  <= '0;
      r_nvy  <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_rx   <= '0;
      r_ry   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (tick) r_ctrl <= '{moveL, moveR, moveF, moveB, turnL, turnR, speed, collide_en};
        ST_ROT0: r_nfx <= w_mp;
        ST_ROT1: r_nfy <= w_mp;
        ST_ROT2: r_nvx <= w_mp;
        ST_ROT3: r_nvy <= w_mp;
        ST_MOVX: r_cx  <= r_px + w_mp;
        ST_MOVY: r_cy  <= r_py + w_mp;
        ST_CHKX: if (w_chk_go) r_rx <= (w_wall && r_ctrl.collide) ? r_px : r_cx;
        ST_CHKY: if (w_chk_go) r_ry <= (w_wall && r_ctrl.collide) ? r_py : r_cy;
        ST_COMMIT: begin
          r_px <= r_rx;
          r_py <= r_ry;
          r_fx <= r_nfx;
          r_fy <= r_nfy;
          r_vx <= r_nvx;
          r_vy <= r_nvy;
        end
        default: ;
      endcase
    end
  end

  // Single-cycle status pulses: update finished, tick arrived while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done   <= 1'b0;
      r_missed <= 1'b0;
    end else begin
      r_done   <= (state == ST_COMMIT);
      r_missed <= tick && (state != ST_IDLE);
    end
  end

  assign busy        = (state != ST_IDLE);
  assign done        = r_done;
  assign missed_tick = r_missed;
  assign playerX     = r_px;
  assign playerY     = r_py;
  assign facingX     = r_fx;
  assign facingY     = r_fy;
  assign vplaneX     = r_vx;
  assign vplaneY     = r_vy;

endmodule
`default_nettype wire

// File: tb/tb_player_motion.sv
`default_nettype none
// ============================================================================
// Module : tb_player_motion
// Desc   : Directed self-checking bench for player_motion. Three instances
//          share controls: default start, Y start near a wall row, and X
//          start near the left map edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_player_motion;

  localparam int W  = 24;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       moveL, moveR, moveF, moveB, turnL, turnR, collide_en, map_ack;
  logic [1:0] speed;
  logic [2:0] tick;

  logic                map_req [3];
  logic                busy    [3];
  logic                done    [3];
  logic                missed  [3];
  logic [MB-1:0]       map_col [3];
  logic [MB-1:0]       map_row [3];
  logic [1:0]          map_val [3];
  logic signed [W-1:0] px [3];
  logic signed [W-1:0] py [3];
  logic signed [W-1:0] fx [3];
  logic signed [W-1:0] fy [3];
  logic signed [W-1:0] vx [3];
  logic signed [W-1:0] vy [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Map: row 12 and column 15 are walls
  function automatic logic [1:0] wall(input logic [MB-1:0] row, input logic [MB-1:0] col);
    return (row == 4'd12 || col == 4'd15) ? 2'd1 : 2'd0;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    player_motion #(
      .X_START (i == 2 ? 32 : 8192),
      .Y_START (i == 1 ? 53312 : 55296)
    ) u_dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick[i]),
      .moveL       (moveL),
      .moveR       (moveR),
      .moveF       (moveF),
      .moveB       (moveB),
      .turnL       (turnL),
      .turnR       (turnR),
      .speed       (speed),
      .collide_en  (collide_en),
      .map_req     (map_req[i]),
      .map_col     (map_col[i]),
      .map_row     (map_row[i]),
      .map_ack     (map_ack),
      .map_val     (map_val[i]),
      .playerX     (px[i]),
      .playerY     (py[i]),
      .facingX     (fx[i]),
      .facingY     (fy[i]),
      .vplaneX     (vx[i]),
      .vplaneY     (vy[i]),
      .busy        (busy[i]),
      .done        (done[i]),
      .missed_tick (missed[i])
    );
    assign map_val[i] = wall(map_row[i], map_col[i]);
  end

  task automatic check_eq(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic l, input logic r, input logic f, input logic b,
                          input logic tl, input logic tr, input logic [1:0] spd, input logic ce);
    moveL = l; moveR = r; moveF = f; moveB = b;
    turnL = tl; turnR = tr; speed = spd; collide_en = ce;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Tick one instance in the current cycle, return cycles until done (40 = timeout)
  task automatic run_tick(input int which, output int cyc);
    tick[which] = 1'b1;
    step();
    tick = '0;
    check_eq("busy_after_tick", busy[which], 1);
    cyc = 1;
    while (!done[which] && cyc < 40) begin
      step();
      cyc++;
    end
  endtask

  task automatic check_start_vec(input string tag, input int i);
    check_eq({tag, "_fx"}, fx[i], 0);
    check_eq({tag, "_fy"}, fy[i], -4096);
    check_eq({tag, "_vx"}, vx[i], 2048);
    check_eq({tag, "_vy"}, vy[i], 0);
  endtask

  initial begin
    int cyc;
    bit saw_done;

    reset   = 1'b0;
    tick    = '0;
    map_ack = 1'b1;
    set_ctrl(0, 0, 0, 0, 0, 0, 2'd0, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    step();

    // Reset state
    check_eq("rst_px", px[0], 8192);
    check_eq("rst_py", py[0], 55296);
    check_start_vec("rst", 0);
    check_eq("rst_done", done[0], 0);
    check_eq("rst_req", map_req[0], 0);
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_missed", missed[0], 0);
    check_eq("rst_col", map_col[0], 0);
    check_eq("rst_row", map_row[0], 0);

    // Forward walk
    set_ctrl(0, 0, 1, 0, 0, 0, 2'd1, 1'b1);
    run_tick(0, cyc);
    check_eq("fwd_latency", cyc, 10);
    check_eq("fwd_px", px[0], 8192);
    check_eq("fwd_py", py[0], 55216);
    check_start_vec("fwd", 0);
    step();
    check_eq("fwd_done_pulse", done[0], 0);
    check_eq("fwd_busy_end", busy[0], 0);

    // Forward + strafe right: diagonal step 56
    do_reset();
    set_ctrl(0, 1, 1, 0, 0, 0, 2'd1, 1'b1);
    run_tick(0, cyc);
    check_eq("diag_latency", cyc, 10);
    check_eq("diag_px", px[0], 8248);
    check_eq("diag_py", py[0], 55240);

    // All four move keys: left and forward win, still diagonal
    do_reset();
    set_ctrl(1, 1, 1, 1, 0, 0, 2'd1, 1'b1);
    run_tick(0, cyc);
    check_eq("prio_px", px[0], 8136);
    check_eq("prio_py", py[0], 55240);

    // Run speed code 3, backwards
    do_reset();
    set_ctrl(0, 0, 0, 1, 0, 0, 2'd3, 1'b1);
    run_tick(0, cyc);
    check_eq("run_px", px[0], 8192);
    check_eq("run_py", py[0], 55440);

    // Crawl forward
    do_reset();
    set_ctrl(0, 0, 1, 0, 0, 0, 2'd0, 1'b1);
    run_tick(0, cyc);
    check_eq("crawl_py", py[0], 55264);

    // Turn right only
    do_reset();
    set_ctrl(0, 0, 0, 0, 0, 1, 2'd1, 1'b1);
    run_tick(0, cyc);
    check_eq("turnr_latency", cyc, 10);
    check_eq("turnr_fx", fx[0], 401);
    check_eq("turnr_fy", fy[0], -4076);
    check_eq("turnr_vx", vx[0], 2038);
    check_eq("turnr_vy", vy[0], 200);
    check_eq("turnr_px", px[0], 8192);
    check_eq("turnr_py", py[0], 55296);

    // Both turn keys: left wins; vplane y floors -200.5 to -201
    do_reset();
    set_ctrl(0, 0, 0, 0, 1, 1, 2'd1, 1'b1);
    run_tick(0, cyc);
    check_eq("turnl_fx", fx[0], -401);
    check_eq("turnl_fy", fy[0], -4076);
    check_eq("turnl_vx", vx[0], 2038);
    check_eq("turnl_vy", vy[0], -201);

    // Wall in row 12 with collision on: Y held
    do_reset();
    set_ctrl(0, 0, 1, 0, 0, 0, 2'd1, 1'b1);
    run_tick(1, cyc);
    check_eq("wall_latency", cyc, 10);
    check_eq("wall_on_py", py[1], 53312);
    check_eq("wall_on_px", px[1], 8192);

    // Same move with collision off: Y accepted
    do_reset();
    set_ctrl(0, 0, 1, 0, 0, 0, 2'd1, 1'b0);
    run_tick(1, cyc);
    check_eq("wall_off_py", py[1], 53232);

    // Left edge: X out of map, no request in CHKX; CHKY ack delayed 3 cycles
    do_reset();
    set_ctrl(1, 0, 0, 0, 0, 0, 2'd1, 1'b1);
    map_ack = 1'b0;
    tick[2] = 1'b1;
    step();
    tick = '0;
    repeat (6) step();
    check_eq("edge_chkx_req", map_req[2], 0);
    check_eq("edge_chkx_busy", busy[2], 1);
    step();
    check_eq("edge_chky_req", map_req[2], 1);
    check_eq("edge_chky_col", map_col[2], 0);
    check_eq("edge_chky_row", map_row[2], 13);
    repeat (3) step();
    check_eq("edge_req_hold", map_req[2], 1);
    check_eq("edge_row_hold", map_row[2], 13);
    map_ack = 1'b1;
    cyc = 11;
    while (!done[2] && cyc < 40) begin
      step();
      cyc++;
    end
    check_eq("edge_latency", cyc, 13);
    check_eq("edge_px", px[2], 32);
    check_eq("edge_py", py[2], 55296);

    // Tick while busy, then reset mid-sequence
    do_reset();
    set_ctrl(0, 0, 1, 0, 0, 0, 2'd1, 1'b1);
    tick[0] = 1'b1;
    step();
    tick = '0;
    step();
    step();
    check_eq("miss_early", missed[0], 0);
    tick[0] = 1'b1;
    step();
    tick = '0;
    check_eq("miss_pulse", missed[0], 1);
    step();
    check_eq("miss_clear", missed[0], 0);
    check_eq("abort_pre_busy", busy[0], 1);
    reset = 1'b0;
    #1;
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_req", map_req[0], 0);
    check_eq("abort_py", py[0], 55296);
    step();
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      step();
      if (done[0]) saw_done = 1'b1;
    end
    check_eq("abort_no_done", saw_done, 0);
    check_eq("abort_py_after", py[0], 55296);
    check_eq("abort_px_after", px[0], 8192);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
